cosim_commit_arbiter: RTL and testbench

//  Collects per-hart retirement records (pc, ir, opNum) from the DUT and serialises them onto one

---
 rtl/cosim_commit_arbiter_pkg.sv | 13 +
 rtl/cosim_commit_fifo.sv | 39 +++
 rtl/cosim_commit_arbiter.sv | 95 +++++++++
 tb/tb_cosim_commit_arbiter.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/cosim_commit_arbiter_pkg.sv
// cosim_commit_arbiter_pkg: shared cosim types for the commit arbiter
package cosim_commit_arbiter_pkg;
  typedef logic [63:0] reg_t;
  typedef logic [63:0] insn_bits_t;
  typedef logic [7:0] uint8_t;
  typedef struct packed {
    reg_t pc;
    insn_bits_t ir;
    uint8_t opNum;
  } cs_commit_t;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} cs_arb_state_t;
  localparam int COSIM_MAX_OP = 16;
endpackage

// File: rtl/cosim_commit_fifo.sv
// cosim_commit_fifo: DEPTH-entry synchronous FIFO of retirement records
module cosim_commit_fifo
  import cosim_commit_arbiter_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  cs_commit_t din,
  output cs_commit_t dout,
  output logic       full,
  output logic       empty
);
  localparam int AW = $clog2(DEPTH);
  cs_commit_t mem [DEPTH];
  logic [AW-1:0] wr, rd;
  logic [AW:0] cnt;
  logic do_push, do_pop;
  assign full = cnt == (AW+1)'(DEPTH);
  assign empty = cnt == '0;
  assign dout = mem[rd];
  assign do_push = push & !full;
  assign do_pop = pop & !empty;
  always_ff @(posedge clk)
    if (do_push) mem[wr] <= din;
  always_ff @(posedge clk) begin
    if (rst) begin
      wr <= '0;
      rd <= '0;
      cnt <= '0;
    end else begin
      if (do_push) wr <= wr + 1'b1;
      if (do_pop) rd <= rd + 1'b1;
      cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/cosim_commit_arbiter.sv
// cosim_commit_arbiter: round-robin serialiser of per-hart retirement records for the cosim checker
module cosim_commit_arbiter
  import cosim_commit_arbiter_pkg::*;
#(
  parameter int NHART = 2,
  parameter int DEPTH = 4,
  parameter int XLEN  = 64,
  parameter int OPW   = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NHART-1:0]      in_valid,
  output logic [NHART-1:0]      in_ready,
  input  logic [NHART*XLEN-1:0] in_pc,
  input  logic [NHART*XLEN-1:0] in_ir,
  input  logic [NHART*OPW-1:0]  in_opnum,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [2:0]            out_pid,
  output logic [XLEN-1:0]       out_pc,
  output logic [XLEN-1:0]       out_ir,
  output logic [OPW-1:0]        out_opnum,
  output logic [31:0]           out_seq,
  input  logic                  drain_req,
  output logic                  drain_done,
  output logic                  err_opnum
);
  localparam int PW = NHART > 1 ? $clog2(NHART) : 1;
  cs_arb_state_t state, state_nx;
  cs_commit_t din [NHART];
  cs_commit_t dout [NHART];
  cs_commit_t slot;
  logic [NHART-1:0] full, empty, push, pop;
  logic [2*NHART-1:0] req2;
  logic [PW-1:0] rr, win;
  logic found, load, vld, bad;
  for (genvar g = 0; g < NHART; g++) begin : g_fifo
    assign din[g] = '{pc: reg_t'(in_pc[g*XLEN +: XLEN]),
                      ir: insn_bits_t'(in_ir[g*XLEN +: XLEN]),
                      opNum: uint8_t'(in_opnum[g*OPW +: OPW])};
    assign push[g] = in_valid[g] & in_ready[g];
    assign pop[g] = load && win == PW'(g);
    cosim_commit_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk(clk), .rst(rst), .push(push[g]), .pop(pop[g]), .din(din[g]),
      .dout(dout[g]), .full(full[g]), .empty(empty[g])
    );
  end
  assign in_ready = {NHART{state == RUN}} & ~full;
  assign out_valid = vld;
  assign load = found & (!vld | out_ready);
  assign drain_done = state == DONE;
  assign out_pc = XLEN'(slot.pc);
  assign out_ir = XLEN'(slot.ir);
  assign out_opnum = OPW'(slot.opNum);
  // rotate the request vector so bit 0 is the hart at rr
  always_comb begin
    found = 1'b0;
    win = rr;
    bad = 1'b0;
    req2 = {~empty, ~empty} >> rr;
    for (int i = 0; i < NHART; i++) begin
      if (!found && req2[i]) begin
        found = 1'b1;
        win = PW'((int'(rr) + i) % NHART);
      end
      if (push[i] && int'(in_opnum[i*OPW +: OPW]) > COSIM_MAX_OP) bad = 1'b1;
    end
  end
  always_comb begin
    state_nx = state == IDLE  ? RUN :
               state == RUN   ? (drain_req ? DRAIN : RUN) :
               state == DRAIN ? ((&empty && !vld) ? DONE : DRAIN) : RUN;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      rr <= '0;
      vld <= 1'b0;
      slot <= '0;
      out_pid <= '0;
      out_seq <= '0;
      err_opnum <= 1'b0;
    end else begin
      state <= state_nx;
      vld <= load | (vld & !out_ready);
      if (load) begin
        slot <= dout[win];
        out_pid <= 3'(win);
        rr <= win == PW'(NHART-1) ? '0 : win + 1'b1;
      end
      if (vld & out_ready) out_seq <= out_seq + 32'd1;
      if (bad) err_opnum <= 1'b1;
    end
  end
endmodule

// File: tb/tb_cosim_commit_arbiter.sv
// tb_cosim_commit_arbiter: directed stimulus with a queue scoreboard and an independent output monitor
module tb_cosim_commit_arbiter;
  logic clk = 0, rst = 1;
  logic [1:0] in_valid = '0;
  logic [1:0] in_ready;
  logic [127:0] in_pc = '0, in_ir = '0;
  logic [9:0] in_opnum = '0;
  logic out_valid, out_ready = 0;
  logic [2:0] out_pid;
  logic [63:0] out_pc, out_ir;
  logic [4:0] out_opnum;
  logic [31:0] out_seq;
  logic drain_req = 0, drain_done, err_opnum;
  typedef struct {
    logic [2:0] pid;
    logic [63:0] pc, ir;
    logic [4:0] op;
    logic [31:0] seq;
  } rec_t;
  rec_t exp_q[$];
  rec_t m;
  logic [31:0] exp_seq = 0;
  int total = 0, passed = 0;
  cosim_commit_arbiter #(.NHART(2), .DEPTH(4), .XLEN(64), .OPW(5)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
    .in_ir(in_ir), .in_opnum(in_opnum), .out_valid(out_valid), .out_ready(out_ready),
    .out_pid(out_pid), .out_pc(out_pc), .out_ir(out_ir), .out_opnum(out_opnum),
    .out_seq(out_seq), .drain_req(drain_req), .drain_done(drain_done), .err_opnum(err_opnum)
  );
  always #5 clk = ~clk;
  task automatic chk(string name, logic [63:0] act, logic [63:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, req);
  endtask
  task automatic expect_rec(int pid, logic [63:0] pc, logic [63:0] ir, logic [4:0] op);
    exp_q.push_back('{3'(pid), pc, ir, op, exp_seq});
    exp_seq++;
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic push(int h, logic [63:0] pc, logic [63:0] ir, logic [4:0] op);
    int n;
    in_pc[h*64 +: 64] = pc;
    in_ir[h*64 +: 64] = ir;
    in_opnum[h*5 +: 5] = op;
    in_valid[h] = 1'b1;
    for (n = 0; n < 200; n++) begin
      @(negedge clk);
      if (in_ready[h]) break;
    end
    if (n == 200) chk("push_timeout", 0, 1);
    @(posedge clk);
    #1 in_valid[h] = 1'b0;
  endtask
  task automatic wait_idle(string name);
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !out_valid) break;
    end
    chk(name, exp_q.size(), 0);
  endtask
  task automatic do_reset();
    rst = 1;
    repeat (2) step();
    rst = 0;
    exp_seq = 0;
    repeat (2) step();
  endtask
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) chk("unexpected_out", 1, 0);
      else begin
        m = exp_q.pop_front();
        chk("out_pid", out_pid, m.pid);
        chk("out_pc", out_pc, m.pc);
        chk("out_ir", out_ir, m.ir);
        chk("out_opnum", out_opnum, m.op);
        chk("out_seq", out_seq, m.seq);
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    repeat (2) step();
    @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_seq", out_seq, 0);
    chk("rst_drain_done", drain_done, 0);
    chk("rst_err", err_opnum, 0);
    @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("ready_idle_cycle", in_ready, 0);
    @(negedge clk);
    chk("ready_run", in_ready, 2'b11);
    step();
    // single hart, in order, two-cycle latency
    out_ready = 1;
    expect_rec(0, 64'h1000, 64'h13, 5'd1);
    push(0, 64'h1000, 64'h13, 5'd1);
    @(negedge clk);
    chk("lat_cycle1", out_valid, 0);
    @(negedge clk);
    chk("lat_cycle2", out_valid, 1);
    step();
    expect_rec(0, 64'h1004, 64'h14, 5'd2);
    push(0, 64'h1004, 64'h14, 5'd2);
    expect_rec(0, 64'h1008, 64'h15, 5'd3);
    push(0, 64'h1008, 64'h15, 5'd3);
    wait_idle("t1_idle");
    step();
    // two harts alternate from hart 0
    do_reset();
    for (int i = 0; i < 4; i++) begin
      expect_rec(0, 64'h2000 + 64'(4*i), 64'hA0 + 64'(i), 5'(i));
      expect_rec(1, 64'h3000 + 64'(4*i), 64'hB0 + 64'(i), 5'(i + 4));
    end
    fork
      for (int i = 0; i < 4; i++) push(0, 64'h2000 + 64'(4*i), 64'hA0 + 64'(i), 5'(i));
      for (int j = 0; j < 4; j++) push(1, 64'h3000 + 64'(4*j), 64'hB0 + 64'(j), 5'(j + 4));
    join
    wait_idle("t2_idle");
    chk("t2_seq", out_seq, 8);
    step();
    // backpressure: DEPTH in FIFO plus one in the slot
    out_ready = 0;
    for (int i = 0; i < 6; i++) expect_rec(0, 64'h4000 + 64'(4*i), 64'hC0 + 64'(i), 5'd7);
    for (int i = 0; i < 5; i++) push(0, 64'h4000 + 64'(4*i), 64'hC0 + 64'(i), 5'd7);
    fork
      push(0, 64'h4014, 64'hC5, 5'd7);
      begin
        repeat (3) begin
          @(negedge clk);
          chk("bp_in_ready", in_ready[0], 0);
          chk("bp_out_valid", out_valid, 1);
          chk("bp_out_pc", out_pc, 64'h4000);
        end
        @(posedge clk);
        #1 out_ready = 1;
      end
    join
    wait_idle("t3_idle");
    step();
    // drain with three queued records
    out_ready = 0;
    expect_rec(0, 64'h5000, 64'hD0, 5'd1);
    expect_rec(1, 64'h6000, 64'hD1, 5'd2);
    expect_rec(0, 64'h5004, 64'hD2, 5'd3);
    push(0, 64'h5000, 64'hD0, 5'd1);
    push(1, 64'h6000, 64'hD1, 5'd2);
    push(0, 64'h5004, 64'hD2, 5'd3);
    drain_req = 1;
    out_ready = 1;
    step();
    drain_req = 0;
    @(negedge clk);
    chk("drain_in_ready", in_ready, 0);
    begin
      int n;
      for (n = 0; n < 50; n++) begin
        if (drain_done) break;
        @(negedge clk);
      end
      chk("drain_done_seen", drain_done, 1);
    end
    chk("drain_delivered", exp_q.size(), 0);
    @(negedge clk);
    chk("drain_done_pulse", drain_done, 0);
    chk("drain_ready_back", in_ready, 2'b11);
    step();
    // opnum overflow flag, then reset mid-stream
    expect_rec(0, 64'h7000, 64'hDEAD, 5'd17);
    push(0, 64'h7000, 64'hDEAD, 5'd17);
    @(negedge clk);
    chk("err_set", err_opnum, 1);
    step();
    expect_rec(1, 64'h7100, 64'hBEEF, 5'd3);
    push(1, 64'h7100, 64'hBEEF, 5'd3);
    wait_idle("t5_idle");
    chk("err_sticky", err_opnum, 1);
    step();
    out_ready = 0;
    push(0, 64'h8000, 64'hE0, 5'd4);
    push(0, 64'h8004, 64'hE1, 5'd4);
    step();
    @(negedge clk);
    chk("pre_rst_valid", out_valid, 1);
    step();
    rst = 1;
    step();
    @(negedge clk);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_out_pc", out_pc, 0);
    chk("mid_rst_out_ir", out_ir, 0);
    chk("mid_rst_out_opnum", out_opnum, 0);
    chk("mid_rst_out_pid", out_pid, 0);
    chk("mid_rst_out_seq", out_seq, 0);
    chk("mid_rst_err", err_opnum, 0);
    chk("mid_rst_in_ready", in_ready, 0);
    @(posedge clk);
    #1 rst = 0;
    exp_seq = 0;
    repeat (2) step();
    out_ready = 1;
    repeat (5) step();
    @(negedge clk);
    chk("no_stale_out", out_valid, 0);
    step();
    // sequence number wrap
    force dut.out_seq = 32'hFFFF_FFFF;
    #1 release dut.out_seq;
    @(negedge clk);
    chk("seq_preload", out_seq, 32'hFFFF_FFFF);
    step();
    exp_seq = 32'hFFFF_FFFF;
    expect_rec(0, 64'h9000, 64'hF0, 5'd5);
    expect_rec(0, 64'h9004, 64'hF1, 5'd6);
    push(0, 64'h9000, 64'hF0, 5'd5);
    push(0, 64'h9004, 64'hF1, 5'd6);
    wait_idle("t6_idle");
    chk("seq_wrap", out_seq, 1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
